// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI-lite arbiter slice.
// States, response codes and transfer-size encodings.
package axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_IFU,
    RD_LSU,
    WR_LSU,
    DRAIN
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bundle shared by the IFU, LSU and memory ports.
// master drives requests; slave drives readies and responses.
interface axi_lite_if;
  import axi_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arsize, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arsize, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_watchdog.sv
// Response watchdog: counts wait cycles, fires at TIMEOUT_CYCLES.
// TIMEOUT_CYCLES of 0 keeps fire permanently low.
module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit ACTIVE = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fire = ACTIVE && enable && (cnt == LIMIT);

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (LSU > IFU) to one-slave AXI-lite arbiter.
// One outstanding transaction, with a response watchdog.
module axi_lite_arbiter
  import axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  ifu_if,
  axi_lite_if.slave  lsu_if,
  axi_lite_if.master mem_if,
  output logic       arb_busy,
  output logic       arb_timeout
);

  arb_state_t state, state_next;
  logic waiting;
  logic wd_fire;
  logic rd_done;
  logic wr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign waiting = (state == RD_IFU) || (state == RD_LSU) ||
                   (state == WR_LSU);
  assign rd_done = mem_if.rvalid && mem_if.rready;
  assign wr_done = mem_if.bvalid && mem_if.bready;
  assign arb_busy = (state != IDLE);

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clear (!waiting),
    .enable(waiting),
    .fire  (wd_fire)
  );

  always_comb begin
    state_next     = state;
    arb_timeout    = 1'b0;

    mem_if.awaddr  = '0;
    mem_if.awvalid = 1'b0;
    mem_if.wdata   = '0;
    mem_if.wstrb   = '0;
    mem_if.wvalid  = 1'b0;
    mem_if.bready  = 1'b0;
    mem_if.araddr  = '0;
    mem_if.arsize  = '0;
    mem_if.arvalid = 1'b0;
    mem_if.rready  = 1'b0;

    ifu_if.awready = 1'b0;
    ifu_if.wready  = 1'b0;
    ifu_if.bresp   = RESP_OKAY;
    ifu_if.bvalid  = 1'b0;
    ifu_if.arready = 1'b0;
    ifu_if.rdata   = '0;
    ifu_if.rresp   = RESP_OKAY;
    ifu_if.rvalid  = 1'b0;

    lsu_if.awready = 1'b0;
    lsu_if.wready  = 1'b0;
    lsu_if.bresp   = RESP_OKAY;
    lsu_if.bvalid  = 1'b0;
    lsu_if.arready = 1'b0;
    lsu_if.rdata   = '0;
    lsu_if.rresp   = RESP_OKAY;
    lsu_if.rvalid  = 1'b0;

    unique case (state)
      IDLE: begin
        if (lsu_if.awvalid || lsu_if.wvalid) state_next = WR_LSU;
        else if (lsu_if.arvalid)             state_next = RD_LSU;
        else if (ifu_if.arvalid)             state_next = RD_IFU;
      end

      RD_IFU: begin
        mem_if.araddr  = ifu_if.araddr;
        mem_if.arsize  = ifu_if.arsize;
        mem_if.arvalid = ifu_if.arvalid;
        mem_if.rready  = ifu_if.rready;
        ifu_if.arready = mem_if.arready;
        ifu_if.rdata   = mem_if.rdata;
        ifu_if.rresp   = mem_if.rresp;
        ifu_if.rvalid  = mem_if.rvalid;
        // A real response in the firing cycle beats the forged one.
        if (rd_done) begin
          state_next = IDLE;
        end else if (wd_fire) begin
          ifu_if.rvalid = 1'b1;
          ifu_if.rresp  = RESP_SLVERR;
          ifu_if.rdata  = '0;
          arb_timeout   = 1'b1;
          state_next    = DRAIN;
        end
      end

      RD_LSU: begin
        mem_if.araddr  = lsu_if.araddr;
        mem_if.arsize  = lsu_if.arsize;
        mem_if.arvalid = lsu_if.arvalid;
        mem_if.rready  = lsu_if.rready;
        lsu_if.arready = mem_if.arready;
        lsu_if.rdata   = mem_if.rdata;
        lsu_if.rresp   = mem_if.rresp;
        lsu_if.rvalid  = mem_if.rvalid;
        if (rd_done) begin
          state_next = IDLE;
        end else if (wd_fire) begin
          lsu_if.rvalid = 1'b1;
          lsu_if.rresp  = RESP_SLVERR;
          lsu_if.rdata  = '0;
          arb_timeout   = 1'b1;
          state_next    = DRAIN;
        end
      end

      WR_LSU: begin
        mem_if.awaddr  = lsu_if.awaddr;
        mem_if.awvalid = lsu_if.awvalid;
        mem_if.wdata   = lsu_if.wdata;
        mem_if.wstrb   = lsu_if.wstrb;
        mem_if.wvalid  = lsu_if.wvalid;
        mem_if.bready  = lsu_if.bready;
        lsu_if.awready = mem_if.awready;
        lsu_if.wready  = mem_if.wready;
        lsu_if.bresp   = mem_if.bresp;
        lsu_if.bvalid  = mem_if.bvalid;
        if (wr_done) begin
          state_next = IDLE;
        end else if (wd_fire) begin
          lsu_if.bvalid = 1'b1;
          lsu_if.bresp  = RESP_SLVERR;
          arb_timeout   = 1'b1;
          state_next    = DRAIN;
        end
      end

      DRAIN: begin
        // Swallow the late response so it never reaches a master.
        mem_if.rready = 1'b1;
        mem_if.bready = 1'b1;
        if (mem_if.rvalid || mem_if.bvalid) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter.
// Main DUT has an 8-cycle watchdog; dut0 has it disabled.
module tb_axi_lite_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arb_busy, arb_timeout;
  logic arb_busy0, arb_timeout0;
  int checks = 0;
  int errors = 0;

  axi_lite_if ifu();
  axi_lite_if lsu();
  axi_lite_if mem();
  axi_lite_if ifu0();
  axi_lite_if lsu0();
  axi_lite_if mem0();

  always #5 clk = ~clk;

  axi_lite_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_if     (ifu),
    .lsu_if     (lsu),
    .mem_if     (mem),
    .arb_busy   (arb_busy),
    .arb_timeout(arb_timeout)
  );

  axi_lite_arbiter #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .ifu_if     (ifu0),
    .lsu_if     (lsu0),
    .mem_if     (mem0),
    .arb_busy   (arb_busy0),
    .arb_timeout(arb_timeout0)
  );

  task automatic init_bus;
    ifu.awaddr = '0; ifu.awvalid = 0; ifu.wdata = '0; ifu.wstrb = '0;
    ifu.wvalid = 0; ifu.bready = 0; ifu.araddr = '0; ifu.arsize = '0;
    ifu.arvalid = 0; ifu.rready = 0;
    lsu.awaddr = '0; lsu.awvalid = 0; lsu.wdata = '0; lsu.wstrb = '0;
    lsu.wvalid = 0; lsu.bready = 0; lsu.araddr = '0; lsu.arsize = '0;
    lsu.arvalid = 0; lsu.rready = 0;
    mem.awready = 0; mem.wready = 0; mem.bresp = '0; mem.bvalid = 0;
    mem.arready = 0; mem.rdata = '0; mem.rresp = '0; mem.rvalid = 0;
    ifu0.awaddr = '0; ifu0.awvalid = 0; ifu0.wdata = '0; ifu0.wstrb = '0;
    ifu0.wvalid = 0; ifu0.bready = 0; ifu0.araddr = '0; ifu0.arsize = '0;
    ifu0.arvalid = 0; ifu0.rready = 0;
    lsu0.awaddr = '0; lsu0.awvalid = 0; lsu0.wdata = '0; lsu0.wstrb = '0;
    lsu0.wvalid = 0; lsu0.bready = 0; lsu0.araddr = '0; lsu0.arsize = '0;
    lsu0.arvalid = 0; lsu0.rready = 0;
    mem0.awready = 0; mem0.wready = 0; mem0.bresp = '0; mem0.bvalid = 0;
    mem0.arready = 0; mem0.rdata = '0; mem0.rresp = '0; mem0.rvalid = 0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    lsu.arvalid = 1; lsu.awvalid = 1; lsu.rready = 1; lsu.bready = 1;
    ifu.arvalid = 1; mem.rvalid = 1; mem.bvalid = 1; mem.arready = 1;
    @(negedge clk); @(negedge clk);
    v = {mem.awvalid, mem.wvalid, mem.bready, mem.arvalid, mem.rready,
         lsu.awready, lsu.wready, lsu.bvalid, lsu.arready, lsu.rvalid,
         ifu.arready, ifu.rvalid, ifu.awready, ifu.bvalid,
         arb_busy, arb_timeout};
    checks++;
    if (v !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0000", v);
    end
    init_bus();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", arb_busy);
    end
  endtask

  task automatic test_ifu_read;
    int busy_n = 0;
    @(negedge clk);
    ifu.araddr = 32'h8000_0000; ifu.arsize = SIZE_WORD;
    ifu.arvalid = 1; ifu.rready = 1;
    #1;
    checks++;
    if (mem.arvalid !== 1'b0) begin
      errors++; $display("FAIL ifu_grant_cycle got %b exp 0", mem.arvalid);
    end
    @(negedge clk); busy_n += int'(arb_busy);
    checks++;
    if (mem.araddr !== 32'h8000_0000 || mem.arvalid !== 1'b1) begin
      errors++; $display("FAIL ifu_ar got %h/%b exp 80000000/1", mem.araddr, mem.arvalid);
    end
    checks++;
    if (mem.arsize !== SIZE_WORD) begin
      errors++; $display("FAIL ifu_arsize got %h exp %h", mem.arsize, SIZE_WORD);
    end
    mem.arready = 1;
    #1;
    checks++;
    if (ifu.arready !== 1'b1 || lsu.arready !== 1'b0) begin
      errors++; $display("FAIL ifu_arready got %b%b exp 10", ifu.arready, lsu.arready);
    end
    @(negedge clk); busy_n += int'(arb_busy);
    ifu.arvalid = 0; mem.arready = 0;
    @(negedge clk); busy_n += int'(arb_busy);
    @(negedge clk); busy_n += int'(arb_busy);
    mem.rvalid = 1; mem.rdata = 32'hDEAD_BEEF; mem.rresp = RESP_OKAY;
    #1;
    checks++;
    if (ifu.rvalid !== 1'b1 || ifu.rdata !== 32'hDEAD_BEEF || ifu.rresp !== 2'b00) begin
      errors++; $display("FAIL ifu_rdata got %b/%h/%h exp 1/deadbeef/0", ifu.rvalid, ifu.rdata, ifu.rresp);
    end
    checks++;
    if (lsu.rvalid !== 1'b0 || mem.rready !== 1'b1) begin
      errors++; $display("FAIL ifu_r_route got %b%b exp 01", lsu.rvalid, mem.rready);
    end
    @(negedge clk); busy_n += int'(arb_busy);
    mem.rvalid = 0; ifu.rready = 0;
    checks++;
    if (busy_n !== 4) begin
      errors++; $display("FAIL ifu_busy_cycles got %0d exp 4", busy_n);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    ifu.araddr = 32'h3000_0000; ifu.arvalid = 1; ifu.rready = 1;
    lsu.araddr = 32'h0F00_0004; lsu.arvalid = 1; lsu.rready = 1;
    @(negedge clk);
    checks++;
    if (mem.araddr !== 32'h0F00_0004) begin
      errors++; $display("FAIL sim_first_addr got %h exp 0f000004", mem.araddr);
    end
    mem.arready = 1;
    #1;
    checks++;
    if (lsu.arready !== 1'b1 || ifu.arready !== 1'b0) begin
      errors++; $display("FAIL sim_arready got %b%b exp 10", lsu.arready, ifu.arready);
    end
    @(negedge clk);
    lsu.arvalid = 0; mem.arready = 0;
    mem.rvalid = 1; mem.rdata = 32'h1111_2222;
    #1;
    checks++;
    if (lsu.rdata !== 32'h1111_2222 || ifu.rvalid !== 1'b0) begin
      errors++; $display("FAIL sim_lsu_r got %h/%b exp 11112222/0", lsu.rdata, ifu.rvalid);
    end
    @(negedge clk);
    mem.rvalid = 0;
    #1;
    checks++;
    if (arb_busy !== 1'b0 || mem.arvalid !== 1'b0) begin
      errors++; $display("FAIL sim_idle_gap got %b%b exp 00", arb_busy, mem.arvalid);
    end
    @(negedge clk);
    checks++;
    if (mem.araddr !== 32'h3000_0000 || mem.arvalid !== 1'b1) begin
      errors++; $display("FAIL sim_ifu_addr got %h/%b exp 30000000/1", mem.araddr, mem.arvalid);
    end
    mem.arready = 1;
    @(negedge clk);
    ifu.arvalid = 0; mem.arready = 0;
    mem.rvalid = 1; mem.rdata = 32'h3333_4444;
    #1;
    checks++;
    if (ifu.rvalid !== 1'b1 || ifu.rdata !== 32'h3333_4444) begin
      errors++; $display("FAIL sim_ifu_r got %b/%h exp 1/33334444", ifu.rvalid, ifu.rdata);
    end
    @(negedge clk);
    mem.rvalid = 0; ifu.rready = 0; lsu.rready = 0;
  endtask

  task automatic test_write;
    int bcnt = 0;
    @(negedge clk);
    lsu.awaddr = 32'h0F00_0002; lsu.awvalid = 1; lsu.bready = 1;
    @(negedge clk);
    checks++;
    if (mem.awvalid !== 1'b1 || mem.awaddr !== 32'h0F00_0002 ||
        mem.wvalid !== 1'b0 || mem.arvalid !== 1'b0) begin
      errors++; $display("FAIL wr_aw got %b/%h/%b/%b exp 1/0f000002/0/0", mem.awvalid, mem.awaddr, mem.wvalid, mem.arvalid);
    end
    mem.awready = 1;
    #1;
    checks++;
    if (lsu.awready !== 1'b1) begin
      errors++; $display("FAIL wr_awready got %b exp 1", lsu.awready);
    end
    @(negedge clk);
    lsu.awvalid = 0; mem.awready = 0;
    lsu.wvalid = 1; lsu.wdata = 32'h00AB_0000; lsu.wstrb = 4'b0100;
    #1;
    checks++;
    if (mem.wvalid !== 1'b1 || mem.wdata !== 32'h00AB_0000 || mem.wstrb !== 4'b0100) begin
      errors++; $display("FAIL wr_w got %b/%h/%b exp 1/00ab0000/0100", mem.wvalid, mem.wdata, mem.wstrb);
    end
    mem.wready = 1;
    @(negedge clk);
    lsu.wvalid = 0; mem.wready = 0;
    bcnt += int'(lsu.bvalid);
    mem.bvalid = 1; mem.bresp = RESP_OKAY;
    #1;
    bcnt += int'(lsu.bvalid);
    checks++;
    if (lsu.bresp !== RESP_OKAY || mem.bready !== 1'b1) begin
      errors++; $display("FAIL wr_b got %h/%b exp 0/1", lsu.bresp, mem.bready);
    end
    @(negedge clk);
    mem.bvalid = 0;
    #1;
    bcnt += int'(lsu.bvalid);
    @(negedge clk);
    bcnt += int'(lsu.bvalid);
    checks++;
    if (bcnt !== 1 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL wr_bvalid_once got %0d/%b exp 1/0", bcnt, arb_busy);
    end
    lsu.bready = 0;
  endtask

  task automatic test_write_priority;
    @(negedge clk);
    lsu.awaddr = 32'h40; lsu.awvalid = 1;
    lsu.wdata = 32'h55; lsu.wstrb = 4'hF; lsu.wvalid = 1;
    lsu.araddr = 32'h44; lsu.arvalid = 1;
    lsu.bready = 1; lsu.rready = 1;
    @(negedge clk);
    checks++;
    if (mem.awvalid !== 1'b1 || mem.wvalid !== 1'b1 || mem.arvalid !== 1'b0) begin
      errors++; $display("FAIL prio_wr_first got %b%b%b exp 110", mem.awvalid, mem.wvalid, mem.arvalid);
    end
    mem.awready = 1; mem.wready = 1;
    #1;
    checks++;
    if (lsu.awready !== 1'b1 || lsu.wready !== 1'b1 || lsu.arready !== 1'b0) begin
      errors++; $display("FAIL prio_readies got %b%b%b exp 110", lsu.awready, lsu.wready, lsu.arready);
    end
    @(negedge clk);
    lsu.awvalid = 0; lsu.wvalid = 0;
    mem.awready = 0; mem.wready = 0; mem.bvalid = 1;
    @(negedge clk);
    mem.bvalid = 0;
    @(negedge clk);
    checks++;
    if (mem.araddr !== 32'h44 || mem.arvalid !== 1'b1) begin
      errors++; $display("FAIL prio_rd_after got %h/%b exp 44/1", mem.araddr, mem.arvalid);
    end
    mem.arready = 1;
    @(negedge clk);
    lsu.arvalid = 0; mem.arready = 0;
    mem.rvalid = 1; mem.rdata = 32'h77;
    #1;
    checks++;
    if (lsu.rvalid !== 1'b1 || lsu.rdata !== 32'h77) begin
      errors++; $display("FAIL prio_rdata got %b/%h exp 1/77", lsu.rvalid, lsu.rdata);
    end
    @(negedge clk);
    mem.rvalid = 0; lsu.rready = 0; lsu.bready = 0;
  endtask

  task automatic test_timeout;
    int fire_k = -1;
    logic leak = 1'b0;
    @(negedge clk);
    lsu.araddr = 32'h100; lsu.arvalid = 1; lsu.rready = 1;
    ifu.araddr = 32'h3000_0100; ifu.arvalid = 1; ifu.rready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      leak |= ifu.arready | ifu.rvalid;
      if (arb_timeout === 1'b1) begin
        fire_k = k;
        checks++;
        if (lsu.rvalid !== 1'b1 || lsu.rresp !== RESP_SLVERR || lsu.rdata !== 32'h0) begin
          errors++; $display("FAIL to_forged got %b/%h/%h exp 1/2/0", lsu.rvalid, lsu.rresp, lsu.rdata);
        end
        break;
      end
      if (k == 0) mem.arready = 1;
      if (k == 1) begin lsu.arvalid = 0; mem.arready = 0; end
    end
    checks++;
    if (fire_k !== 8) begin
      errors++; $display("FAIL to_fire_cycle got %0d exp 8", fire_k);
    end
    @(negedge clk);
    checks++;
    if (arb_busy !== 1'b1 || arb_timeout !== 1'b0 || lsu.rvalid !== 1'b0) begin
      errors++; $display("FAIL to_drain got %b%b%b exp 100", arb_busy, arb_timeout, lsu.rvalid);
    end
    checks++;
    if (mem.rready !== 1'b1 || mem.bready !== 1'b1 || mem.arvalid !== 1'b0) begin
      errors++; $display("FAIL to_drain_mem got %b%b%b exp 110", mem.rready, mem.bready, mem.arvalid);
    end
    @(negedge clk);
    leak |= ifu.arready | ifu.rvalid;
    @(negedge clk);
    mem.rvalid = 1; mem.rdata = 32'h99;
    #1;
    leak |= ifu.arready | ifu.rvalid | lsu.rvalid;
    checks++;
    if (leak !== 1'b0) begin
      errors++; $display("FAIL to_blocked got %b exp 0", leak);
    end
    @(negedge clk);
    mem.rvalid = 0;
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL to_back_idle got %b exp 0", arb_busy);
    end
    @(negedge clk);
    checks++;
    if (mem.araddr !== 32'h3000_0100 || mem.arvalid !== 1'b1) begin
      errors++; $display("FAIL to_ifu_next got %h/%b exp 30000100/1", mem.araddr, mem.arvalid);
    end
    mem.arready = 1;
    @(negedge clk);
    ifu.arvalid = 0; mem.arready = 0; mem.rvalid = 1; mem.rdata = 32'h5;
    @(negedge clk);
    mem.rvalid = 0; ifu.rready = 0; lsu.rready = 0;
  endtask

  task automatic test_no_watchdog;
    int bad = 0;
    @(negedge clk);
    lsu0.araddr = 32'h200; lsu0.arvalid = 1; lsu0.rready = 1;
    @(negedge clk);
    mem0.arready = 1;
    @(negedge clk);
    lsu0.arvalid = 0; mem0.arready = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      bad += int'(arb_timeout0) + int'(lsu0.rvalid) + int'(!arb_busy0);
    end
    mem0.rvalid = 1; mem0.rdata = 32'hCAFE_F00D; mem0.rresp = RESP_OKAY;
    #1;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL nowd_no_fire got %0d exp 0", bad);
    end
    checks++;
    if (lsu0.rvalid !== 1'b1 || lsu0.rdata !== 32'hCAFE_F00D || lsu0.rresp !== 2'b00) begin
      errors++; $display("FAIL nowd_rdata got %b/%h/%h exp 1/cafef00d/0", lsu0.rvalid, lsu0.rdata, lsu0.rresp);
    end
    @(negedge clk);
    mem0.rvalid = 0; lsu0.rready = 0;
    checks++;
    if (arb_busy0 !== 1'b0) begin
      errors++; $display("FAIL nowd_idle got %b exp 0", arb_busy0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    lsu.awaddr = 32'h0F00_0010; lsu.awvalid = 1; lsu.bready = 1;
    @(negedge clk);
    mem.awready = 1;
    @(negedge clk);
    lsu.awvalid = 0; mem.awready = 0;
    lsu.wvalid = 1; lsu.wdata = 32'h1234; lsu.wstrb = 4'hF;
    mem.wready = 1;
    #1;
    checks++;
    if (mem.wvalid !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got %b exp 1", mem.wvalid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mem.wvalid, mem.bready, lsu.wready, arb_busy} !== 4'b0) begin
      errors++; $display("FAIL rmid_async got %b%b%b%b exp 0000", mem.wvalid, mem.bready, lsu.wready, arb_busy);
    end
    lsu.wvalid = 0; mem.wready = 0;
    @(negedge clk);
    rst = 1'b0;
    mem.bvalid = 1;
    #1;
    checks++;
    if (lsu.bvalid !== 1'b0 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL rmid_late_b got %b%b exp 00", lsu.bvalid, arb_busy);
    end
    @(negedge clk);
    mem.bvalid = 0; lsu.bready = 0;
    ifu.araddr = 32'h8000_0040; ifu.arvalid = 1; ifu.rready = 1;
    @(negedge clk);
    mem.arready = 1;
    #1;
    checks++;
    if (mem.araddr !== 32'h8000_0040 || ifu.arready !== 1'b1) begin
      errors++; $display("FAIL rmid_ifu_ar got %h/%b exp 80000040/1", mem.araddr, ifu.arready);
    end
    @(negedge clk);
    ifu.arvalid = 0; mem.arready = 0;
    mem.rvalid = 1; mem.rdata = 32'h1234_5678;
    #1;
    checks++;
    if (ifu.rvalid !== 1'b1 || ifu.rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rmid_ifu_r got %b/%h exp 1/12345678", ifu.rvalid, ifu.rdata);
    end
    @(negedge clk);
    mem.rvalid = 0; ifu.rready = 0;
  endtask

  initial begin
    init_bus();
    test_reset();
    test_ifu_read();
    test_simultaneous();
    test_write();
    test_write_priority();
    test_timeout();
    test_no_watchdog();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit got expired exp finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter placed directly downstream of the LSU data-memory master port and the IFU fetch master port.
- Serialises their transactions onto the single memory/peripheral bus; only one transaction is outstanding at any time.
- Fixed priority: LSU over IFU.
- Response watchdog: a hung slave returns SLVERR instead of deadlocking the core.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles a granted transaction may wait for R/B before the arbiter forges an error response; 0 disables the watchdog.
- CNT_W, 10: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  reset, asynchronous, active-high.
- ifu_if  axi_lite_if.slave  -  from IFU; read channels only used; AW/W inputs ignored, awready/wready/bvalid tied 0.
- lsu_if  axi_lite_if.slave  -  from LSU; full read and write channels.
- mem_if  axi_lite_if.master  -  to memory/peripheral slave.
- arb_busy  output  1  high whenever state != IDLE.
- arb_timeout  output  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, RD_IFU, RD_LSU, WR_LSU, DRAIN. Reset (async) -> IDLE, counter 0.
- Reset values while rst high:
  - all mem_if valids/readies 0;
  - all master readies 0, rvalid 0, bvalid 0;
  - arb_busy 0, arb_timeout 0.
- IDLE:
  - all master readies 0; mem_if valids 0.
  - Grant decision on registered sample, next state:
    - lsu awvalid|wvalid -> WR_LSU;
    - else lsu arvalid -> RD_LSU;
    - else ifu arvalid -> RD_IFU.
  - Priority order: LSU write > LSU read > IFU read.
  - Grant costs exactly one cycle. Masters hold valid per AXI rule, so no request is lost.
- RD_x:
  - Granted master's AR and R channels pass combinationally to/from mem_if: araddr, arsize, arvalid, arready, rdata, rresp, rvalid, rready.
  - Non-granted master sees arready=0, rvalid=0.
  - Exit to IDLE on mem_if.rvalid & rready.
- WR_LSU:
  - AW, W and B pass through; AW and W handshakes may complete in any order or the same cycle.
  - Exit to IDLE on mem_if.bvalid & bready.
  - mem_if AR held invalid.
- Back-to-back: an IDLE cycle always separates transactions, so minimum occupancy is 1 grant cycle plus slave latency.
- Watchdog:
  - Counter clears on entry to any RD/WR state and increments each cycle while waiting.
  - At count == TIMEOUT_CYCLES, the arbiter drives the granted master's rvalid (rresp=2'b10, rdata=0) or bvalid (bresp=2'b10) for one cycle, pulses arb_timeout, and moves to DRAIN.
  - If the slave responds in that same cycle, the real response wins and there is no timeout.
- DRAIN:
  - mem_if rready=bready=1; all master channels blocked.
  - Returns to IDLE when the late rvalid/bvalid arrives.
  - Masters stall meanwhile (arb_busy=1).
- Simultaneous requests: IFU read and LSU read asserted the same IDLE cycle -> LSU granted; IFU waits and is granted the next IDLE.
- LSU AW and AR both asserted -> write served first.
- Reset mid-transaction: immediate return to IDLE. Any slave response after reset is not forwarded; the slave is responsible for its own reset.
- Byte lanes, sizes and addresses are never modified; arbitration is transparent to data.

Decomposition:
- Shared package (axi_pkg): state enum arb_state_t; AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; arsize encodings.
- One sub-module, axi_lite_watchdog: counter with clear/enable/fire, parameterised on TIMEOUT_CYCLES and CNT_W.
- Channel muxing stays in the top module.

Test Plan:
- IFU read 0x8000_0000, slave returns 0xDEADBEEF after 3 cycles -> ifu rdata=0xDEADBEEF, rresp=0; LSU channels idle; arb_busy high 4 cycles.
- IFU and LSU arvalid same cycle (0x3000_0000, 0x0F00_0004) -> mem_if sees 0x0F00_0004 first; IFU address issued only after LSU rvalid&rready plus one IDLE cycle.
- LSU write 0x0F00_0002, wdata 0x00AB0000, wstrb 0b0100, AW one cycle before W -> mem_if receives identical awaddr/wdata/wstrb; lsu bvalid once after slave B.
- Slave never answers an LSU read, TIMEOUT_CYCLES=8 -> lsu rvalid with rresp=2'b10 at cycle 8 after grant; arb_timeout pulse; state DRAIN until a late rvalid, then IDLE; IFU blocked meanwhile.
- rst asserted in WR_LSU after AW handshake -> all outputs 0 asynchronously; a later slave bvalid is not forwarded; a new IFU read after rst release completes normally.
- TIMEOUT_CYCLES=0, slave latency 2000 cycles -> no timeout, correct data returned.
